// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, in-order imem requester and 2-entry instruction buffer feeding decode.
// Stale responses after a redirect are counted in r_drop and discarded without using a FIFO slot.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [6:0]  id_opcode,
  output logic [2:0]  id_funct3
);
  logic [31:0] r_pc;
  logic [31:0] r_instr [2];
  logic [31:0] r_fpc [2];
  logic [31:0] r_tag [2];
  logic        r_rd, r_wr, r_tag_rd, r_tag_wr;
  logic [1:0]  r_count, r_live;
  logic [2:0]  r_drop;
  logic        w_fire_id, w_fire_req, w_push, w_credit;
  logic [31:0] w_target;

  assign w_fire_id      = id_valid & id_ready;
  assign w_fire_req     = imem_req_valid & imem_req_ready;
  assign w_push         = imem_rsp_valid & (r_drop == 3'd0);
  // r_live counts only non-stale in-flight requests, so it alone shares the credit with r_count
  assign w_credit       = ({1'b0, r_count} + {1'b0, r_live}) < 3'd2;
  assign w_target       = redirect_pc & ~32'h3;
  assign imem_req_valid = !reset & !redirect_valid & (w_credit | w_fire_id);
  assign imem_req_addr  = r_pc;
  assign id_valid       = r_count != 2'd0;
  assign id_instr       = r_instr[r_rd];
  assign id_pc          = r_fpc[r_rd];
  assign id_pc_plus4    = id_pc + 32'd4;
  assign id_opcode      = id_instr[6:0];
  assign id_funct3      = id_instr[14:12];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_instr[0] <= '0;
      r_instr[1] <= '0;
      r_fpc[0]   <= '0;
      r_fpc[1]   <= '0;
      r_tag[0]   <= '0;
      r_tag[1]   <= '0;
      r_rd       <= 1'b0;
      r_wr       <= 1'b0;
      r_tag_rd   <= 1'b0;
      r_tag_wr   <= 1'b0;
      r_count    <= '0;
      r_live     <= '0;
      r_drop     <= '0;
    end else if (redirect_valid) begin
      r_pc     <= w_target;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_tag_rd <= 1'b0;
      r_tag_wr <= 1'b0;
      r_count  <= '0;
      r_live   <= '0;
      r_drop   <= r_drop + 3'(r_live) - 3'(imem_rsp_valid);
    end else begin
      if (w_fire_req) begin
        r_pc            <= r_pc + 32'd4;
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= ~r_tag_wr;
      end
      if (w_push) begin
        r_instr[r_wr] <= imem_rsp_data;
        r_fpc[r_wr]   <= r_tag[r_tag_rd];
        r_wr          <= ~r_wr;
        r_tag_rd      <= ~r_tag_rd;
      end
      if (w_fire_id) r_rd <= ~r_rd;
      if (imem_rsp_valid && r_drop != 3'd0) r_drop <= r_drop - 3'd1;
      r_count <= r_count + 2'(w_push) - 2'(w_fire_id);
      r_live  <= r_live + 2'(w_fire_req) - 2'(w_push);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && !redirect_valid) assert (!(w_push && r_count == 2'd2));
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a latency-L in-order memory model.
module tb_fetch_unit;
  logic        clk, reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, id_valid, id_ready;
  logic [31:0] redirect_pc, id_instr, id_pc, id_pc_plus4;
  logic [6:0]  id_opcode;
  logic [2:0]  id_funct3;

  fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .id_opcode(id_opcode), .id_funct3(id_funct3)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct { logic [31:0] addr; int due; } req_t;
  req_t mq[$];
  int checks = 0, errors = 0, cyc = 0, lat = 1;
  logic [31:0] m_pc, exp_pc, obs_addr, obs_pc, obs_plus4, obs_instr;
  logic        obs_req, obs_fire, obs_idv, obs_rsp;
  logic [6:0]  obs_op;
  logic [2:0]  obs_f3;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h300) ? 32'h00A3_7033 : a ^ 32'hC0DE_0000;
  endfunction

  task automatic step(input logic rq_rdy, input logic id_rdy, input logic redir, input logic [31:0] tgt);
    logic        fire_req;
    logic [31:0] w;
    imem_req_ready = rq_rdy;
    id_ready       = id_rdy;
    redirect_valid = redir;
    redirect_pc    = tgt;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    obs_req = imem_req_valid; obs_addr = imem_req_addr; obs_idv = id_valid;
    obs_fire = id_valid & id_ready; obs_pc = id_pc; obs_plus4 = id_pc_plus4;
    obs_instr = id_instr; obs_op = id_opcode; obs_f3 = id_funct3; obs_rsp = imem_rsp_valid;
    chk("req_addr", obs_addr, m_pc);
    if (obs_fire) begin
      w = mem_word(exp_pc);
      chk("id_pc", obs_pc, exp_pc);
      chk("id_instr", obs_instr, w);
      chk("id_pc_plus4", obs_plus4, exp_pc + 32'd4);
      chk("id_opcode", {25'b0, obs_op}, {25'b0, w[6:0]});
      chk("id_funct3", {29'b0, obs_f3}, {29'b0, w[14:12]});
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) exp_pc = {tgt[31:2], 2'b00};
    fire_req = obs_req & rq_rdy;
    @(posedge clk);
    if (obs_rsp) void'(mq.pop_front());
    if (fire_req) mq.push_back('{obs_addr, cyc + lat});
    if (redir) m_pc = {tgt[31:2], 2'b00};
    else if (fire_req) m_pc = m_pc + 32'd4;
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    reset = 0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
    redirect_valid = 0; redirect_pc = 0; id_ready = 0;
    m_pc = 32'h100; exp_pc = 32'h100;
    #1 reset = 1;
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_id_valid", id_valid, 0);
    chk("rst_id_instr", id_instr, 0);
    chk("rst_id_pc", id_pc, 0);
    chk("rst_id_pc_plus4", id_pc_plus4, 32'h4);
    chk("rst_req_addr", imem_req_addr, 32'h100);
    @(negedge clk);
    @(negedge clk);
    reset = 0;

    // streaming at L=1
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0);
      chk("t1_req_valid", obs_req, 1);
      chk("t1_addr", obs_addr, 32'h100 + 32'(4 * i));
      if (i == 1) chk("t1_idv_c1", obs_idv, 0);
      if (i == 2) begin
        chk("t1_idv_c2", obs_idv, 1);
        chk("t1_first_pc", obs_pc, 32'h100);
        chk("t1_first_plus4", obs_plus4, 32'h104);
      end
    end

    // decode stall: FIFO fills, requests stop, head held
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      chk("stall_req_valid", obs_req, 0);
      chk("stall_id_pc", obs_pc, 32'h110);
    end
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);

    // L=3 with toggling request ready
    lat = 3;
    for (int i = 0; i < 14; i++) step(i % 2 == 0, 1, 0, 0);

    // redirect with two requests outstanding
    begin : t4
      bit got;
      bit seen;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin
        step(1, 1, 0, 0);
        got = (mq.size() == 2);
      end
      chk("t4_two_inflight", {31'b0, got}, 1);
      step(1, 1, 1, 32'h203);
      chk("t4_redir_no_req", obs_req, 0);
      step(1, 1, 0, 0);
      chk("t4_target_req", obs_req, 1);
      chk("t4_target_addr", obs_addr, 32'h200);
      seen = obs_fire;
      for (int i = 0; i < 20 && !seen; i++) begin
        step(1, 1, 0, 0);
        seen = obs_fire;
      end
      chk("t4_first_seen", {31'b0, seen}, 1);
      chk("t4_first_pc", obs_pc, 32'h200);
    end

    // redirect coinciding with a response and a decode handshake, L=1
    lat = 1;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h300);
    chk("t5_coinc_rsp", obs_rsp, 1);
    chk("t5_coinc_fire", obs_fire, 1);
    step(1, 1, 0, 0);
    chk("t5_flush_idv", obs_idv, 0);
    chk("t5_req", obs_req, 1);
    step(1, 1, 0, 0);
    chk("t5_idv_r2", obs_idv, 0);
    step(1, 1, 0, 0);
    chk("t5_idv_r3", obs_idv, 1);
    chk("t5_pc_r3", obs_pc, 32'h300);
    chk("t5_instr", obs_instr, 32'h00A3_7033);
    chk("t5_opcode", {25'b0, obs_op}, 32'h33);
    chk("t5_funct3", {29'b0, obs_f3}, 32'h7);

    // PC wrap
    step(1, 1, 1, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    chk("wrap_a0", obs_addr, 32'hFFFF_FFF8);
    step(1, 1, 0, 0);
    chk("wrap_a1", obs_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0);
    chk("wrap_a2", obs_addr, 32'h0);
    chk("wrap_a2_valid", obs_req, 1);
    step(1, 1, 0, 0);
    chk("wrap_head_pc", obs_pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", obs_plus4, 32'h0);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

    // asynchronous reset with the FIFO full
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("full_idv", obs_idv, 1);
    reset = 1;
    #1;
    chk("areset_id_valid", id_valid, 0);
    chk("areset_req_valid", imem_req_valid, 0);
    mq.delete();
    m_pc = 32'h100;
    exp_pc = 32'h100;
    @(negedge clk);
    reset = 0;
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0);
    chk("post_rst_pc", obs_pc, 32'h108);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
